// File: rtl/rca_multicycle_adder_if.sv
// Operand/result bundle for the multi-cycle ripple-carry adder/subtractor.
// The requester drives start/sub/cin/in1/in2; the adder returns busy/done and the result.
`timescale 1ns/1ps
interface rca_multicycle_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, cin, in1, in2,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, cin, in1, in2,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/rca_multicycle_adder.sv
// Ripple-carry adder/subtractor that processes CHUNK bits per clock over WIDTH/CHUNK cycles,
// with the inter-chunk carry held in a register and a start/busy/done handshake.
`timescale 1ns/1ps
module rca_multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic               clock,
    input  logic               reset,
    rca_multicycle_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [KW-1:0]    k_q;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;

    assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last   = (k_q == KW'(NCHUNK - 1));

    always_comb begin
        a_chunk   = a_q[k_q*CHUNK +: CHUNK];
        b_chunk   = b_q[k_q*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the chunk MSB recovered from its sum bit: s = a ^ b ^ c.
        msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = bus.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else if (accept) begin
            a_q     <= bus.in1;
            b_q     <= bus.sub ? ~bus.in2 : bus.in2;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            k_q     <= '0;
        end else if (state == RUN) begin
            sum_q[k_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
            carry_q                   <= chunk_sum[CHUNK];
            k_q                       <= k_q + KW'(1);
            if (last) begin
                cout_q <= chunk_sum[CHUNK];
                ovf_q  <= msb_cin ^ chunk_sum[CHUNK];
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
